reader_fifo: RTL and testbench

- Parametrised successor to the team's serial-in/parallel-out reader.
- Deserialises a framed serial bit stream (mosi, qualified by enable) into WIDTH-bit words, with selectable bit order.
- Adds a bit counter, abort of partial words, and a first-word-fall-through output FIFO with a valid/ready handshake, occupancy count and overrun flag.
- Sits between the serial link front end and word-oriented consumers in the same sclk domain.

---
 rtl/reader_fifo.sv | 142 ++++++++++++++
 tb/tb_reader_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reader_fifo.sv
// reader_fifo: serial-in word deserialiser feeding a first-word-fall-through FIFO.
// Bits on mosi are sampled while enable is high and assembled into WIDTH-bit
// words (bit order set by MSB_FIRST). Completed words enter a 2**DEPTH_LOG2 FIFO
// with a valid/ready output. A word is dropped if it completes while the FIFO is full.
// Dropping a word sets the sticky overrun flag.
// If enable falls mid-word, the partial word is discarded and abort pulses.
// Optional feature macro: READER_PARITY_EN. Each frame then carries one
// even-parity bit after the data, and the head word's parity error appears on dout_perr.
module reader_fifo #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  sclk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  mosi,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_perr,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overrun,
  output logic                  abort
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
`ifdef READER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
  localparam int unsigned EW    = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
  localparam int unsigned EW    = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             last_bit;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [EW-1:0]    push_word;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Next shift-register value and frame-completion detection.
  always_comb begin
    shreg_nxt = shreg;
    if (MSB_FIRST != 0) begin
      shreg_nxt = {shreg[WIDTH-2:0], mosi};
    end else begin
      shreg_nxt = {mosi, shreg[WIDTH-1:1]};
    end
    last_bit = enable && (bit_cnt == CNT_W'(FRAME - 1));
`ifdef READER_PARITY_EN
    // The data is already complete when the parity bit arrives.
    push_word = {(^shreg) ^ mosi, shreg};
`else
    push_word = shreg_nxt;
`endif
  end

  assign full       = (fifo_count == CW'(DEPTH));
  assign dout_valid = (fifo_count != '0);
  assign pop        = dout_valid && dout_ready;
  // A push while full is still accepted when a pop frees the head slot on the same edge.
  assign push_ok    = last_bit && (!full || pop);

  assign dout = dout_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
`ifdef READER_PARITY_EN
  assign dout_perr = dout_valid ? mem[rd_ptr][WIDTH] : 1'b0;
`else
  assign dout_perr = 1'b0;
`endif

  // Bit counter, shift register and abort pulse.
  always_ff @(posedge sclk) begin
    if (clear) begin
      bit_cnt <= '0;
      shreg   <= '0;
      abort   <= 1'b0;
    end else if (enable) begin
      abort <= 1'b0;
      if (last_bit) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
`ifdef READER_PARITY_EN
      if (bit_cnt != CNT_W'(WIDTH)) begin
        shreg <= shreg_nxt;
      end
`else
      shreg <= shreg_nxt;
`endif
    end else if (bit_cnt != '0) begin
      bit_cnt <= '0;
      shreg   <= '0;
      abort   <= 1'b1;
    end else begin
      abort <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overrun.
  always_ff @(posedge sclk) begin
    if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push_ok) begin
        fifo_count <= fifo_count - CW'(1);
      end
      if (last_bit && !push_ok) begin
        overrun <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge sclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

endmodule

// File: tb/tb_reader_fifo.sv
// tb_reader_fifo: drives one serial stream into an MSB-first and an LSB-first
// reader_fifo and checks both against a frame/queue-level reference model.
module tb_reader_fifo;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
`ifdef READER_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic         sclk = 1'b0;
  logic         clear = 1'b1;
  logic         enable = 1'b0;
  logic         mosi = 1'b0;
  logic         dout_ready = 1'b0;

  logic [W-1:0] dout_a, dout_b;
  logic         valid_a, valid_b, perr_a, perr_b, ovr_a, ovr_b, abort_a, abort_b;
  logic [2:0]   count_a, count_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] w;
    logic         perr;
  } ent_t;

  bit   bits[$];
  ent_t qa[$];
  ent_t qb[$];
  logic m_ovr = 1'b0;
  logic m_abort = 1'b0;

  always #5 sclk = ~sclk;

  reader_fifo #(.WIDTH(W), .DEPTH_LOG2(2), .MSB_FIRST(1)) dut_a (
    .sclk(sclk), .clear(clear), .enable(enable), .mosi(mosi),
    .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready),
    .dout_perr(perr_a), .fifo_count(count_a), .overrun(ovr_a), .abort(abort_a)
  );

  reader_fifo #(.WIDTH(W), .DEPTH_LOG2(2), .MSB_FIRST(0)) dut_b (
    .sclk(sclk), .clear(clear), .enable(enable), .mosi(mosi),
    .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready),
    .dout_perr(perr_b), .fifo_count(count_b), .overrun(ovr_b), .abort(abort_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: collects frame bits, builds words arithmetically, queues them.
  task automatic model_edge();
    logic         done;
    logic         popv;
    ent_t         ea;
    ent_t         eb;
    logic         par;
    done = 1'b0;
    popv = (qa.size() != 0) && dout_ready;
    ea.w = '0; ea.perr = 1'b0;
    eb.w = '0; eb.perr = 1'b0;
    if (clear) begin
      bits.delete(); qa.delete(); qb.delete();
      m_ovr = 1'b0; m_abort = 1'b0;
      return;
    end
    m_abort = 1'b0;
    if (enable) begin
      bits.push_back(mosi);
      if (bits.size() == FRAME) begin
        par = 1'b0;
        for (int i = 0; i < FRAME; i++) par = par ^ bits[i];
        for (int i = 0; i < W; i++) begin
          ea.w = ea.w | (W'(bits[i]) << (W - 1 - i));
          eb.w = eb.w | (W'(bits[i]) << i);
        end
`ifdef READER_PARITY_EN
        ea.perr = par;
`else
        ea.perr = 1'b0;
`endif
        eb.perr = ea.perr;
        done = 1'b1;
        bits.delete();
      end
    end else if (bits.size() != 0) begin
      m_abort = 1'b1;
      bits.delete();
    end
    if (popv) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (done) begin
      if (qa.size() < DEPTH) begin
        qa.push_back(ea);
        qb.push_back(eb);
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [W-1:0] ha, hb;
    logic         pa;
    ha = (qa.size() != 0) ? qa[0].w : '0;
    hb = (qb.size() != 0) ? qb[0].w : '0;
    pa = (qa.size() != 0) ? qa[0].perr : 1'b0;
    chk("a_dout",  64'(dout_a),  64'(ha));
    chk("a_valid", 64'(valid_a), 64'(qa.size() != 0));
    chk("a_count", 64'(count_a), 64'(qa.size()));
    chk("a_perr",  64'(perr_a),  64'(pa));
    chk("a_ovr",   64'(ovr_a),   64'(m_ovr));
    chk("a_abort", 64'(abort_a), 64'(m_abort));
    chk("b_dout",  64'(dout_b),  64'(hb));
    chk("b_valid", 64'(valid_b), 64'(qb.size() != 0));
    chk("b_count", 64'(count_b), 64'(qb.size()));
    chk("b_perr",  64'(perr_b),  64'(pa));
    chk("b_ovr",   64'(ovr_b),   64'(m_ovr));
    chk("b_abort", 64'(abort_b), 64'(m_abort));
  endtask

  task automatic step(input logic c, input logic en, input logic m, input logic rdy);
    clear = c; enable = en; mosi = m; dout_ready = rdy;
    @(posedge sclk);
    model_edge();
    #1;
    check_all();
  endtask

  // One frame, first bit = w[7]; ready only on the final edge when rdy_last is set.
  task automatic send(input logic [W-1:0] w, input logic pbit, input logic rdy_last);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, v[W-1-i], (i == W - 1) && (FRAME == W) && rdy_last);
    end
    if (FRAME != W) step(1'b0, 1'b1, pbit, rdy_last);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 64'(count_a), 64'd0);

    // Single word; LSB-first instance sees the bit-reversed value
    send(8'hA5, 1'b0, 1'b0);
    chk("a5_a", 64'(dout_a), 64'hA5);
    chk("a5_b", 64'(dout_b), 64'hA5);
    pop_one();
    chk("a5_empty", 64'(valid_a), 64'd0);
    send(8'hC0, 1'b0, 1'b0);
    chk("c0_a", 64'(dout_a), 64'hC0);
    chk("c0_b", 64'(dout_b), 64'h03);
    pop_one();

    // Abort after 5 bits, then a clean word
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_pulse", 64'(abort_a), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_once", 64'(abort_a), 64'd0);
    send(8'h3C, 1'b0, 1'b0);
    chk("3c_a", 64'(dout_a), 64'h3C);
    pop_one();

    // Fill, overrun, drain past empty
    for (int i = 1; i <= 5; i++) send(W'(i), 1'b0, 1'b0);
    chk("full_count", 64'(count_a), 64'd4);
    chk("ovr_set", 64'(ovr_a), 64'd1);
    for (int i = 0; i < 5; i++) pop_one();
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Push and pop on the same edge while full
    send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0); send(8'h44, 1'b0, 1'b0);
    send(8'h99, 1'b0, 1'b1);
    chk("pp_count", 64'(count_a), 64'd4);
    chk("pp_ovr", 64'(ovr_a), 64'd0);
    for (int i = 0; i < 5; i++) pop_one();

    // Parity good then bad (parity bit ignored without the feature)
    send(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    pop_one();
    pop_one();

    // Clear mid-frame with enable still high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_valid", 64'(valid_a), 64'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 88),
           1'($urandom), ($urandom_range(0, 99) < 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
